// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / debug) round-robin arbiter in front of a
// single-port synchronous 256x16 RAM. Each access takes IDLE -> ACCESS ->
// RESP, so at most one access completes every three cycles.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [7:0]  dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [7:0]  ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        busy,
    output logic        last_grant
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_last_grant;  // also identifies the owner of the live transaction
    logic        r_rd;          // live transaction is a read
    logic [7:0]  r_ram_addr;
    logic        r_ram_we;
    logic [15:0] r_ram_wdata;
    logic        r_cpu_ack;
    logic        r_dbg_ack;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_dbg_rdata;

    logic        w_grant;
    logic        w_gnt_dbg;
    logic        w_sel_we;
    logic [7:0]  w_sel_addr;
    logic [15:0] w_sel_wdata;

    // Next-state and grant decision; a tie goes to the port that did not win last.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt_dbg   = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (cpu_req && dbg_req) begin
                    w_grant   = 1'b1;
                    w_gnt_dbg = ~r_last_grant;
                end else if (cpu_req) begin
                    w_grant   = 1'b1;
                    w_gnt_dbg = 1'b0;
                end else if (dbg_req) begin
                    w_grant   = 1'b1;
                    w_gnt_dbg = 1'b1;
                end
                if (w_grant) w_state_nxt = S_ACCESS;
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Request mux for the winning port.
    always_comb begin
        w_sel_we    = w_gnt_dbg ? dbg_we    : cpu_we;
        w_sel_addr  = w_gnt_dbg ? dbg_addr  : cpu_addr;
        w_sel_wdata = w_gnt_dbg ? dbg_wdata : cpu_wdata;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // RAM command registers: loaded on grant, write enable lives only in ACCESS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_addr   <= 8'h00;
            r_ram_wdata  <= 16'h0000;
            r_ram_we     <= 1'b0;
            r_rd         <= 1'b0;
            r_last_grant <= 1'b1;   // CPU wins the first tie after reset
        end else begin
            r_ram_we <= 1'b0;
            if (w_grant) begin
                r_ram_addr   <= w_sel_addr;
                r_ram_wdata  <= w_sel_wdata;
                r_ram_we     <= w_sel_we;
                r_rd         <= ~w_sel_we;
                r_last_grant <= w_gnt_dbg;
            end
        end
    end

    // Owner ack: set leaving ACCESS so it is high for the RESP cycle only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
        end else begin
            r_cpu_ack <= (r_state == S_ACCESS) && !r_last_grant;
            r_dbg_ack <= (r_state == S_ACCESS) &&  r_last_grant;
        end
    end

    // Read data capture at the edge ending RESP; writes leave both registers alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_rdata <= 16'h0000;
            r_dbg_rdata <= 16'h0000;
        end else if (r_state == S_RESP && r_rd) begin
            if (r_last_grant) r_dbg_rdata <= ram_rdata;
            else              r_cpu_rdata <= ram_rdata;
        end
    end

    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;
    assign cpu_ack    = r_cpu_ack;
    assign dbg_ack    = r_dbg_ack;
    assign cpu_rdata  = r_cpu_rdata;
    assign dbg_rdata  = r_dbg_rdata;
    assign last_grant = r_last_grant;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 cpu_req  input  1  CPU access request; held high until cpu_ack.
REQ-005 cpu_we  input  1  CPU write (1) / read (0); stable while cpu_req high.
REQ-006 cpu_addr  input  8  CPU word address; stable while cpu_req high.
REQ-007 cpu_wdata  input  16  CPU write data; stable while cpu_req high.
REQ-008 cpu_rdata  output  16  CPU read data, registered.
REQ-009 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-010 dbg_req, dbg_we, dbg_addr[7:0], dbg_wdata[15:0]  input  debug/loader port; same rules as the CPU port.
REQ-011 dbg_rdata  output  16; dbg_ack  output  1; same rules as the CPU port.
REQ-012 ram_addr  output  8  address to single-port synchronous RAM (256 x 16), registered.
REQ-013 ram_we  output  1  RAM write enable, registered.
REQ-014 ram_wdata  output  16  RAM write data, registered.
REQ-015 ram_rdata  input  16  RAM read data, valid one cycle after the RAM samples ram_addr.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 last_grant  output  1  owner of the most recent grant: 0 = CPU, 1 = debug.

Function
REQ-018 The block SHALL implement states IDLE, ACCESS and RESP.
REQ-019 IDLE: no request -> stay; exactly one request -> grant that port; both -> grant the port not equal to last_grant (round-robin); on grant, register addr/we/wdata onto ram_*, update last_grant, go to ACCESS.
REQ-020 ACCESS: ram_we equals the owner's we for exactly this one cycle; next state RESP unconditionally.
REQ-021 RESP: ram_we = 0; the owner's ack = 1 for exactly this cycle; for a read, the owner's rdata loads ram_rdata at the edge ending RESP; next state IDLE.
REQ-022 The non-owner's ack and rdata SHALL remain unchanged (ack 0) throughout another port's transaction.
REQ-023 A write SHALL NOT modify either rdata register.
REQ-024 Latency: request sampled in IDLE at edge k -> ACCESS after k, RESP after k+1, ack high in the cycle after edge k+1; read data is visible on rdata after edge k+2.
REQ-025 Throughput: at most one access per 3 cycles; with both ports requesting continuously, grants strictly alternate.
REQ-026 A requester SHALL drop req in the cycle after ack; a req still high in IDLE is treated as a new request.
REQ-027 Requests arriving while busy are ignored until IDLE; they are not queued or lost while req is held.
REQ-028 ram_we SHALL be 0 in every state except ACCESS.
REQ-029 Addresses wrap naturally within 8 bits; no range checking is performed.

Reset
REQ-030 reset_n low SHALL immediately force state = IDLE, busy = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, cpu_ack = dbg_ack = 0, cpu_rdata = dbg_rdata = 0, and last_grant = 1, so the CPU wins the first tie.
REQ-031 Reset asserted during ACCESS or RESP SHALL abort the transaction: no ack and no rdata update for it, and ram_we drops without waiting for a clock.
REQ-032 After release, the first rising edge with reset_n high SHALL evaluate requests normally from IDLE.

Verification
REQ-033 CPU write addr 8'h19 data 16'hFFE9, then CPU read addr 8'h19 -> ram_we high for exactly 1 cycle; cpu_ack on the 2nd cycle after each request is sampled; cpu_rdata = 16'hFFE9; dbg_ack never high.
REQ-034 cpu_req and dbg_req both asserted in the first cycle after reset -> CPU granted first (last_grant = 0), debug granted next (last_grant = 1); both acks pulse once, 3 cycles apart.
REQ-035 Both ports request continuously for 6 transactions -> grant order CPU, DBG, CPU, DBG, CPU, DBG; busy low for exactly 1 cycle between transactions.
REQ-036 Debug writes 16'h1234 to addr 8'h00 while a CPU read of addr 8'hFF is pending -> the CPU read completes first and returns the RAM content at 8'hFF; the debug write follows; cpu_rdata is unchanged by the write.
REQ-037 reset_n pulsed low in the ACCESS cycle of a CPU write -> ram_we falls immediately, no cpu_ack, all outputs at reset values, and the next request completes normally.
REQ-038 Debug read of addr 8'h7F with ram_rdata driven to 16'hA5A5 -> dbg_rdata = 16'hA5A5; cpu_rdata keeps its prior value.
